// File: rtl/dcc_window_sequencer_if.sv
// Record-RAM read port, HPS PIO window and capture-side flow control of the sequencer.
// The sequencer drives the master modport; RAM, capture block and PIO bridge sit on the slave side.
interface dcc_window_sequencer_if #(
    parameter int ADDR_W  = 10,
    parameter int WORDS   = 32,
    parameter int WORD_AW = 5
);
    logic [ADDR_W:0]           wr_ptr;
    logic [ADDR_W+WORD_AW-1:0] rec_rd_addr;
    logic [31:0]               rec_rd_data;
    logic                      hps_read_bit;
    logic [32*WORDS-1:0]       dcc_data;
    logic                      window_valid;
    logic [31:0]               buff_diff;
    logic [31:0]               pulse_num;
    logic                      buf_full;
    logic                      ack_err;

    modport master (
        input  wr_ptr, rec_rd_data, hps_read_bit,
        output rec_rd_addr, dcc_data, window_valid, buff_diff, pulse_num, buf_full, ack_err
    );

    modport slave (
        output wr_ptr, rec_rd_data, hps_read_bit,
        input  rec_rd_addr, dcc_data, window_valid, buff_diff, pulse_num, buf_full, ack_err
    );
endinterface

// File: rtl/dcc_window_sequencer.sv
// Copies one record per HPS acknowledge from record RAM into a shadow bank and publishes it atomically.
// WORDS+3 cycles empty-to-valid, WORDS+4 toggle-to-next; capture writer stalled by buf_full at 2^ADDR_W pending.
module dcc_window_sequencer #(
    parameter int ADDR_W  = 10,
    parameter int WORDS   = 32,
    parameter int WORD_AW = 5
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset_n,
    dcc_window_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, LOAD, PUBLISH, WAIT} state_t;

    localparam logic [ADDR_W:0]  FULL_DIFF = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [WORD_AW:0] LAST_CNT  = (WORD_AW+1)'(WORDS);
    localparam logic [WORD_AW:0] LAST_ADDR = (WORD_AW+1)'(WORDS - 1);

    state_t                   state;
    logic [ADDR_W:0]          rd_ptr;
    logic [ADDR_W:0]          diff;
    logic [WORD_AW:0]         cnt;
    logic [WORD_AW-1:0]       cap_idx;
    logic [WORD_AW-1:0]       nxt_word;
    logic [WORDS-1:0][31:0]   shadow;
    logic                     ack_q;
    logic                     ack_armed;
    logic                     tog;

    assign diff          = bus.wr_ptr - rd_ptr;
    assign bus.buf_full  = (diff == FULL_DIFF);
    // ack_armed keeps the first post-reset sample of hps_read_bit from looking like a toggle.
    assign tog           = ack_armed & (bus.hps_read_bit ^ ack_q);
    assign cap_idx       = cnt[WORD_AW-1:0] - WORD_AW'(1);
    assign nxt_word      = cnt[WORD_AW-1:0] + WORD_AW'(1);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state            <= IDLE;
            rd_ptr           <= '0;
            cnt              <= '0;
            shadow           <= '0;
            ack_q            <= 1'b0;
            ack_armed        <= 1'b0;
            bus.rec_rd_addr  <= '0;
            bus.dcc_data     <= '0;
            bus.window_valid <= 1'b0;
            bus.buff_diff    <= '0;
            bus.pulse_num    <= '0;
            bus.ack_err      <= 1'b0;
        end else begin
            ack_q         <= bus.hps_read_bit;
            ack_armed     <= 1'b1;
            bus.buff_diff <= {{(31-ADDR_W){1'b0}}, diff};
            if (tog && state != WAIT) begin
                bus.ack_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (diff != '0) begin
                        state           <= LOAD;
                        cnt             <= '0;
                        bus.rec_rd_addr <= {rd_ptr[ADDR_W-1:0], {WORD_AW{1'b0}}};
                    end
                end
                LOAD: begin
                    // RAM data trails the address by one cycle, so capture lags the address by one word.
                    if (cnt != '0) begin
                        shadow[cap_idx] <= bus.rec_rd_data;
                    end
                    if (cnt < LAST_ADDR) begin
                        bus.rec_rd_addr <= {rd_ptr[ADDR_W-1:0], nxt_word};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state <= PUBLISH;
                    end
                end
                PUBLISH: begin
                    bus.dcc_data     <= shadow;
                    bus.window_valid <= 1'b1;
                    state            <= WAIT;
                end
                WAIT: begin
                    if (tog) begin
                        bus.window_valid <= 1'b0;
                        rd_ptr           <= rd_ptr + 1'b1;
                        bus.pulse_num    <= bus.pulse_num + 32'd1;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
